dmem_slave: RTL and testbench



---
 rtl/dmem_slave.sv | 211 +++++++++++++++++++++
 tb/tb_dmem_slave.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_slave.sv
// -----------------------------------------------------------------------------
// dmem_slave
//   Single-port data memory slave for the core's load/store interface.
//   Accepts one transaction per grant (req/gnt handshake) and returns a single
//   rvalid pulse RSP_LATENCY cycles after the grant cycle. The grant can be
//   held back by GNT_DELAY cycles so the LSU stall paths see wait states.
//
// Parameters
//   MEM_DEPTH   : number of 32-bit words (word index = data_addr_i[31:2])
//   GNT_DELAY   : cycles req must be held before gnt asserts (0..15)
//   RSP_LATENCY : cycles from grant cycle to rvalid cycle (1..15)
//
// Ports
//   clk_i         : clock, rising edge
//   rst_ni        : asynchronous active-low reset
//   data_req_i    : request, held by the master until granted
//   data_gnt_o    : one-cycle grant pulse; transaction accepted this cycle
//   data_rvalid_o : one-cycle response pulse
//   data_addr_i   : byte address, bits [1:0] ignored
//   data_we_i     : 1 = write, 0 = read
//   data_be_i     : byte enables, bit n covers bits [8n+7:8n]
//   data_wdata_i  : write data
//   data_rdata_o  : read data, meaningful while data_rvalid_o = 1
//   data_err_o    : out-of-range access flag, meaningful while data_rvalid_o = 1
// -----------------------------------------------------------------------------
module dmem_slave #(
    parameter int MEM_DEPTH   = 1024,
    parameter int GNT_DELAY   = 0,
    parameter int RSP_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int         DATA_W = 32;
    localparam int         AW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] GNT_D  = 4'(GNT_DELAY);
    localparam logic [3:0] RSP_L  = 4'(RSP_LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;      // grant wait-state counter
    logic [3:0]  lat_q, lat_d;      // response latency counter
    logic        gnt;
    logic        accept;
    logic        rsp_due;
    logic        load_rsp;

    logic [29:0]       word_idx;
    logic [AW-1:0]     mem_idx;
    logic              in_range;
    logic [DATA_W-1:0] rsp_word;
    logic              unused_addr_lsb;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic [DATA_W-1:0] rsp_data_p1;
    logic              rsp_err_p1;
    logic [DATA_W-1:0] rsp_data_p2;
    logic              rsp_err_p2;

    assign word_idx        = data_addr_i[31:2];
    assign mem_idx         = word_idx[AW-1:0];
    assign in_range        = ({2'b00, word_idx} < 32'(MEM_DEPTH));
    assign unused_addr_lsb = ^data_addr_i[1:0];

    // Writes and out-of-range accesses answer with zero data.
    assign rsp_word = (!data_we_i && in_range) ? mem[mem_idx] : '0;

    // -------------------------------------------------------------------------
    // Control FSM: grant generation and response timing
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        gnt     = 1'b0;
        rsp_due = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_req_i) begin
                    if (GNT_DELAY == 0) begin
                        gnt     = 1'b1;
                        state_d = RESP;
                        lat_d   = 4'd1;
                    end else begin
                        state_d = WAIT_GNT;
                        cnt_d   = 4'd1;
                    end
                end
            end
            WAIT_GNT: begin
                if (!data_req_i) begin
                    // Master withdrew the request: abort without side effects.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == GNT_D) begin
                    gnt     = 1'b1;
                    state_d = RESP;
                    cnt_d   = '0;
                    lat_d   = 4'd1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                if (lat_q == RSP_L) begin
                    rsp_due = 1'b1;
                    state_d = IDLE;
                    lat_d   = '0;
                    // The rvalid cycle doubles as an IDLE cycle so a waiting
                    // master can be granted back-to-back.
                    if (data_req_i) begin
                        if (GNT_DELAY == 0) begin
                            gnt     = 1'b1;
                            state_d = RESP;
                            lat_d   = 4'd1;
                        end else begin
                            state_d = WAIT_GNT;
                            cnt_d   = 4'd1;
                        end
                    end
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                lat_d   = '0;
            end
        endcase
    end

    // Grant is combinational from req; masking with rst_ni keeps it (and the
    // memory write it triggers) silent while reset is held.
    assign accept = gnt & rst_ni;

    // Output stage is loaded on the edge that opens the rvalid cycle: directly
    // from the memory at the grant edge for single-cycle latency, otherwise
    // from the response captured at grant.
    assign load_rsp = (accept && (RSP_LATENCY == 1)) ||
                      ((state_q == RESP) && !rsp_due && ((lat_q + 4'd1) == RSP_L));

    // -------------------------------------------------------------------------
    // Stage p1: grant edge -- commit write bytes, capture response
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (accept) begin
            if (data_we_i && in_range) begin
                for (int b = 0; b < 4; b++) begin
                    if (data_be_i[b]) begin
                        mem[mem_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                    end
                end
            end
            rsp_data_p1 <= rsp_word;
            rsp_err_p1  <= !in_range;
        end
    end

    // -------------------------------------------------------------------------
    // Stage p2: response outputs, held between rvalid pulses
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_data_p2 <= '0;
            rsp_err_p2  <= 1'b0;
        end else if (load_rsp) begin
            if (accept) begin
                rsp_data_p2 <= rsp_word;
                rsp_err_p2  <= !in_range;
            end else begin
                rsp_data_p2 <= rsp_data_p1;
                rsp_err_p2  <= rsp_err_p1;
            end
        end
    end

    assign data_gnt_o    = accept;
    assign data_rvalid_o = rsp_due;
    assign data_rdata_o  = rsp_data_p2;
    assign data_err_o    = rsp_err_p2 & rsp_due;

endmodule

// File: tb/tb_dmem_slave.sv
// -----------------------------------------------------------------------------
// tb_dmem_slave
//   Three instances of dmem_slave with different timing parameters:
//     inst 0 : GNT_DELAY=0, RSP_LATENCY=1
//     inst 1 : GNT_DELAY=3, RSP_LATENCY=2
//     inst 2 : GNT_DELAY=0, RSP_LATENCY=3
//   Directed scenarios followed by randomized traffic checked against a
//   word-array reference model.
// -----------------------------------------------------------------------------
module tb_dmem_slave;

    logic        clk;
    logic        rst_n  [3];
    logic        req    [3];
    logic        gnt    [3];
    logic        rvalid [3];
    logic [31:0] addr   [3];
    logic        we     [3];
    logic [3:0]  be     [3];
    logic [31:0] wdata  [3];
    logic [31:0] rdata  [3];
    logic        err    [3];

    logic [31:0] mdl [3][1024];
    int          n_cmp;
    int          n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_slave #(.MEM_DEPTH(1024), .GNT_DELAY(0), .RSP_LATENCY(1)) u0 (
        .clk_i(clk), .rst_ni(rst_n[0]), .data_req_i(req[0]), .data_gnt_o(gnt[0]),
        .data_rvalid_o(rvalid[0]), .data_addr_i(addr[0]), .data_we_i(we[0]),
        .data_be_i(be[0]), .data_wdata_i(wdata[0]), .data_rdata_o(rdata[0]),
        .data_err_o(err[0]));

    dmem_slave #(.MEM_DEPTH(1024), .GNT_DELAY(3), .RSP_LATENCY(2)) u1 (
        .clk_i(clk), .rst_ni(rst_n[1]), .data_req_i(req[1]), .data_gnt_o(gnt[1]),
        .data_rvalid_o(rvalid[1]), .data_addr_i(addr[1]), .data_we_i(we[1]),
        .data_be_i(be[1]), .data_wdata_i(wdata[1]), .data_rdata_o(rdata[1]),
        .data_err_o(err[1]));

    dmem_slave #(.MEM_DEPTH(1024), .GNT_DELAY(0), .RSP_LATENCY(3)) u2 (
        .clk_i(clk), .rst_ni(rst_n[2]), .data_req_i(req[2]), .data_gnt_o(gnt[2]),
        .data_rvalid_o(rvalid[2]), .data_addr_i(addr[2]), .data_we_i(we[2]),
        .data_be_i(be[2]), .data_wdata_i(wdata[2]), .data_rdata_o(rdata[2]),
        .data_err_o(err[2]));

    function automatic int gd_of(input int k);
        return (k == 1) ? 3 : 0;
    endfunction

    function automatic int lat_of(input int k);
        return k + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at 1 time unit after a rising edge. Raises req, waits for gnt,
    // applies the transaction to the reference model and returns the expected
    // response. Returns 1 time unit after the grant edge with req dropped and
    // the other inputs scrambled.
    task automatic grant(input int k, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d, input string tag,
                         output logic [31:0] exp_rd, output logic exp_err);
        int          n;
        bit          got;
        int unsigned wi;
        logic [31:0] mask;
        req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            if (gnt[k] === 1'b1) got = 1'b1;
            else n++;
        end
        chk({tag, "_gnt_wait"}, 32'(n), 32'(gd_of(k)));
        wi = 32'(a[31:2]);
        if (wi >= 1024) begin
            exp_err = 1'b1;
            exp_rd  = '0;
        end else begin
            exp_err = 1'b0;
            if (w) begin
                mask = '0;
                for (int i = 0; i < 4; i++)
                    if (b[i]) mask = mask | (32'hFF << (8 * i));
                if (got) mdl[k][wi] = (mdl[k][wi] & ~mask) | (d & mask);
                exp_rd = '0;
            end else begin
                exp_rd = mdl[k][wi];
            end
        end
        @(posedge clk); #1;
        req[k] = 1'b0; we[k] = 1'($urandom); addr[k] = $urandom;
        be[k] = 4'($urandom); wdata[k] = $urandom;
    endtask

    // Waits for rvalid after a grant, checks latency and payload, then checks
    // that rdata holds through the following idle cycle.
    task automatic resp(input int k, input logic [31:0] exp_rd, input logic exp_err,
                        input string tag);
        int n;
        bit got;
        n = 1; got = 1'b0;
        while (!got && n <= 40) begin
            @(negedge clk);
            if (rvalid[k] === 1'b1) got = 1'b1;
            else n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(lat_of(k)));
        chk({tag, "_rdata"}, rdata[k], exp_rd);
        chk({tag, "_err"}, 32'(err[k]), 32'(exp_err));
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_rvalid_pulse"}, 32'(rvalid[k]), 32'd0);
        chk({tag, "_rdata_hold"}, rdata[k], exp_rd);
        @(posedge clk); #1;
    endtask

    task automatic txn(input int k, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d, input string tag);
        logic [31:0] er;
        logic        ee;
        grant(k, w, a, b, d, tag, er, ee);
        resp(k, er, ee, tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] er;
        logic        ee;
        logic [31:0] a;
        n_cmp = 0;
        n_fail = 0;
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0;
            be[k] = '0; wdata[k] = '0;
            for (int i = 0; i < 1024; i++) mdl[k][i] = 'x;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_gnt%0d", k), 32'(gnt[k]), 32'd0);
            chk($sformatf("rst_rvalid%0d", k), 32'(rvalid[k]), 32'd0);
            chk($sformatf("rst_rdata%0d", k), rdata[k], 32'd0);
            chk($sformatf("rst_err%0d", k), 32'(err[k]), 32'd0);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        @(posedge clk); #1;

        // Full write then read, zero wait states
        txn(0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, "t1_wr");
        grant(0, 1'b0, 32'h10, 4'b0000, 32'h0, "t1_rd", er, ee);
        resp(0, 32'hDEADBEEF, 1'b0, "t1_rd");

        // Partial byte-enable write
        txn(0, 1'b1, 32'h10, 4'b0101, 32'h11223344, "t2_wr");
        grant(0, 1'b0, 32'h13, 4'b0000, 32'h0, "t2_rd", er, ee);
        resp(0, 32'hDE22BE44, 1'b0, "t2_rd");

        // Empty byte-enable write leaves memory untouched
        txn(0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, "be0_wr");
        grant(0, 1'b0, 32'h10, 4'b0000, 32'h0, "be0_rd", er, ee);
        resp(0, 32'hDE22BE44, 1'b0, "be0_rd");

        // Back-to-back reads
        txn(0, 1'b1, 32'h0, 4'b1111, 32'd1, "b2b_pre0");
        txn(0, 1'b1, 32'h4, 4'b1111, 32'd2, "b2b_pre1");
        txn(0, 1'b1, 32'h8, 4'b1111, 32'd3, "b2b_pre2");
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0; be[0] = 4'hF;
        @(negedge clk);
        chk("b2b_gnt0", 32'(gnt[0]), 32'd1);
        chk("b2b_rv0", 32'(rvalid[0]), 32'd0);
        @(posedge clk); #1; addr[0] = 32'h4;
        @(negedge clk);
        chk("b2b_gnt1", 32'(gnt[0]), 32'd1);
        chk("b2b_rv1", 32'(rvalid[0]), 32'd1);
        chk("b2b_rd1", rdata[0], 32'd1);
        @(posedge clk); #1; addr[0] = 32'h8;
        @(negedge clk);
        chk("b2b_gnt2", 32'(gnt[0]), 32'd1);
        chk("b2b_rv2", 32'(rvalid[0]), 32'd1);
        chk("b2b_rd2", rdata[0], 32'd2);
        @(posedge clk); #1; req[0] = 1'b0;
        @(negedge clk);
        chk("b2b_gnt3", 32'(gnt[0]), 32'd0);
        chk("b2b_rv3", 32'(rvalid[0]), 32'd1);
        chk("b2b_rd3", rdata[0], 32'd3);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_rv4", 32'(rvalid[0]), 32'd0);
        @(posedge clk); #1;

        // Out of range write and read; word 0 unchanged
        grant(0, 1'b1, 32'h1000, 4'b1111, 32'h55, "oor_wr", er, ee);
        resp(0, 32'h0, 1'b1, "oor_wr");
        grant(0, 1'b0, 32'h1000, 4'b0000, 32'h0, "oor_rd", er, ee);
        resp(0, 32'h0, 1'b1, "oor_rd");
        grant(0, 1'b0, 32'h0, 4'b0000, 32'h0, "oor_w0", er, ee);
        resp(0, 32'd1, 1'b0, "oor_w0");

        // Grant wait states and request abort
        txn(1, 1'b1, 32'h10, 4'b1111, 32'hA5A5_0F0F, "gd_wr");
        txn(1, 1'b0, 32'h10, 4'b0000, 32'h0, "gd_rd");
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h10; be[1] = 4'hF; wdata[1] = 32'h0BAD_0BAD;
        @(negedge clk);
        chk("abort_gnt_c0", 32'(gnt[1]), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_gnt_c1", 32'(gnt[1]), 32'd0);
        @(posedge clk); #1; req[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("abort_gnt_%0d", i), 32'(gnt[1]), 32'd0);
            chk($sformatf("abort_rv_%0d", i), 32'(rvalid[1]), 32'd0);
            @(posedge clk); #1;
        end
        txn(1, 1'b0, 32'h10, 4'b0000, 32'h0, "abort_after");

        // Reset during a pending response
        txn(2, 1'b1, 32'h14, 4'b1111, 32'hCAFE_F00D, "rs_pre");
        txn(2, 1'b0, 32'h14, 4'b0000, 32'h0, "rs_rd0");
        grant(2, 1'b0, 32'h14, 4'b0000, 32'h0, "rs_rd1", er, ee);
        rst_n[2] = 1'b0;
        #1;
        chk("rs_gnt", 32'(gnt[2]), 32'd0);
        chk("rs_rvalid", 32'(rvalid[2]), 32'd0);
        chk("rs_rdata", rdata[2], 32'd0);
        chk("rs_err", 32'(err[2]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rs_norv_%0d", i), 32'(rvalid[2]), 32'd0);
        end
        @(posedge clk); #1; rst_n[2] = 1'b1;
        @(posedge clk); #1;
        txn(2, 1'b0, 32'h14, 4'b0000, 32'h0, "rs_after");
        grant(2, 1'b1, 32'h18, 4'b1111, 32'h1357_9BDF, "rs_wr", er, ee);
        rst_n[2] = 1'b0;
        @(posedge clk); #1; rst_n[2] = 1'b1;
        @(posedge clk); #1;
        txn(2, 1'b0, 32'h18, 4'b0000, 32'h0, "rs_wr_kept");

        // Randomized traffic against the reference model
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++)
                txn(k, 1'b1, 32'(i << 2), 4'b1111, $urandom, $sformatf("pl%0d", k));
            for (int t = 0; t < 30; t++) begin
                if ($urandom_range(0, 7) == 0)
                    a = 32'($urandom_range(1024, 1100) << 2) | 32'($urandom_range(0, 3));
                else
                    a = 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
                txn(k, 1'($urandom), a, 4'($urandom), $urandom,
                    $sformatf("rnd%0d_%0d", k, t));
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
